// File: rtl/movement_mapper_if.sv
// rtl/movement_mapper_if.sv - movement code in, mapped code and update strobe out
interface movement_mapper_if #(
  parameter int W = 4
);
  logic [W-1:0] movement;
  logic [1:0]   mode;
  logic         enable;
  logic [W-1:0] mappedMovement;
  logic         valid;

  modport master (output movement, mode, enable, input mappedMovement, valid);
  modport slave  (input movement, mode, enable, output mappedMovement, valid);
endinterface

// File: rtl/movement_mapper.sv
// rtl/movement_mapper.sv - synchronise, debounce and transform a movement code
module movement_mapper #(
  parameter int W             = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  movement_mapper_if.slave  bus
);
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [W-1:0]  sync1_q, sync1_d;
  logic [W-1:0]  sync2_q, sync2_d;
  logic [W-1:0]  candidate_q, candidate_d;
  logic [W-1:0]  stable_q, stable_d;
  logic [W-1:0]  mapped_q, mapped_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          valid_q, valid_d;
  logic          commit;

  function automatic logic [W-1:0] xform(input logic [W-1:0] x, input logic [1:0] m);
    logic [W-1:0] r;
    r = x;
    case (m)
      2'b00:   r = x;
      2'b01:   r = -x;
      2'b10:   r = ~x;
      default: for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    endcase
    return r;
  endfunction

  always_comb begin
    sync1_d     = bus.movement;
    sync2_d     = sync1_q;
    candidate_d = candidate_q;
    cnt_d       = cnt_q;
    stable_d    = stable_q;
    mapped_d    = mapped_q;
    mode_d      = mode_q;
    valid_d     = 1'b0;

    // Counter keeps running while disabled so a saturated candidate commits on re-enable.
    if (sync2_q != candidate_q) begin
      candidate_d = sync2_q;
      cnt_d       = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    commit = bus.enable && (sync2_q == candidate_q) && (cnt_q == CNT_MAX)
             && (candidate_q != stable_q);

    if (commit) begin
      stable_d = candidate_q;
      mapped_d = xform(candidate_q, bus.mode);
      mode_d   = bus.mode;
      valid_d  = 1'b1;
    end else if (bus.enable && (bus.mode != mode_q)) begin
      mapped_d = xform(stable_q, bus.mode);
      mode_d   = bus.mode;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      candidate_q <= '0;
      stable_q    <= '0;
      mapped_q    <= '0;
      cnt_q       <= '0;
      mode_q      <= 2'b00;
      valid_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      candidate_q <= candidate_d;
      stable_q    <= stable_d;
      mapped_q    <= mapped_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.mappedMovement = mapped_q;
  assign bus.valid          = valid_q;
endmodule

// File: tb/tb_movement_mapper.sv
// tb/tb_movement_mapper.sv - directed vectors against a run-length behavioural model
module tb_movement_mapper;
  localparam int W = 4;
  localparam int S = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   vc = 0;

  always #5 clk = ~clk;

  movement_mapper_if #(.W(W)) bus ();

  movement_mapper #(.W(W), .STABLE_CYCLES(S)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [W-1:0] f_model(input logic [W-1:0] x, input logic [1:0] m);
    int v;
    int r;
    v = int'(x);
    r = 0;
    case (m)
      2'b00: r = v;
      2'b01: r = ((1 << W) - v) % (1 << W);
      2'b10: r = ((1 << W) - 1) - v;
      default: for (int i = 0; i < W; i++) r = r * 2 + ((v >> i) & 1);
    endcase
    return r[W-1:0];
  endfunction

  // Model: the value seen two samples late must repeat for S+1 edges to commit.
  logic [W-1:0] m_s1, m_s2, m_last, m_stable, m_map;
  logic [1:0]   m_mode;
  logic         m_valid;
  int           m_run;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_last = '0; m_run = 1;
      m_stable = '0; m_map = '0; m_mode = 2'b00; m_valid = 1'b0;
    end else begin
      if (m_s2 == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
      else m_run = 1;
      m_last  = m_s2;
      m_valid = 1'b0;
      if (bus.enable && m_run >= S + 1 && m_s2 != m_stable) begin
        m_stable = m_s2;
        m_mode   = bus.mode;
        m_map    = f_model(m_s2, bus.mode);
        m_valid  = 1'b1;
      end else if (bus.enable && bus.mode != m_mode) begin
        m_mode  = bus.mode;
        m_map   = f_model(m_stable, bus.mode);
        m_valid = 1'b1;
      end
      m_s2 = m_s1;
      m_s1 = bus.movement;
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (bus.valid) vc++;
    if (bus.valid !== m_valid || bus.mappedMovement !== m_map) begin
      miscompares++;
      $display("FAIL cycle_compare t=%0t: valid=%b mapped=%b, required valid=%b mapped=%b",
               $time, bus.valid, bus.mappedMovement, m_valid, m_map);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name, input logic [W-1:0] exp, input int exp_n);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.valid && n < 40);
    vectors++;
    if (!bus.valid || n != exp_n || bus.mappedMovement !== exp) begin
      miscompares++;
      $display("FAIL %s: valid=%b after %0d edges value=%b, required valid after %0d edges value=%b",
               name, bus.valid, n, bus.mappedMovement, exp_n, exp);
    end
  endtask

  int v0;

  initial begin
    reset_n      = 1'b0;
    bus.movement = '0;
    bus.mode     = 2'b00;
    bus.enable   = 1'b1;
    step(3);
    chk("reset_mapped", 32'(bus.mappedMovement), 32'h0);
    chk("reset_valid", 32'(bus.valid), 32'h0);
    reset_n = 1'b1;
    step(8);
    chk("idle_no_valid", 32'(vc), 32'h0);

    bus.movement = 4'b0011;
    wait_valid("latency_0011", 4'b0011, 7);
    @(posedge clk); #1;
    chk("single_pulse", 32'(bus.valid), 32'h0);

    // Negate sweep from a clean reset.
    step(1);
    bus.movement = 4'b0000;
    bus.mode     = 2'b01;
    reset_n      = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(4);
    v0 = vc;
    step(10);
    chk("neg_0000_no_valid", 32'(vc - v0), 32'h0);
    bus.movement = 4'b0001;
    wait_valid("neg_0001", 4'b1111, 7);
    step(3);
    bus.movement = 4'b1000;
    wait_valid("neg_1000", 4'b1000, 7);
    step(3);
    bus.movement = 4'b1111;
    wait_valid("neg_1111", 4'b0001, 7);
    step(3);

    // Bounce between two patterns, never long enough to commit.
    bus.mode = 2'b00;
    step(3);
    v0 = vc;
    for (int i = 0; i < 6; i++) begin
      bus.movement = (i % 2 == 0) ? 4'b0101 : 4'b1010;
      step(2);
    end
    chk("bounce_no_valid", 32'(vc - v0), 32'h0);
    bus.movement = 4'b0101;
    wait_valid("bounce_settle", 4'b0101, 7);
    step(3);

    bus.movement = 4'b0110;
    wait_valid("stable_0110", 4'b0110, 7);
    step(1);
    bus.mode = 2'b11;
    wait_valid("mode_reverse", 4'b0110, 1);
    step(1);
    bus.mode = 2'b10;
    wait_valid("mode_invert", 4'b1001, 1);
    step(2);

    bus.enable   = 1'b0;
    bus.movement = 4'b0001;
    bus.mode     = 2'b01;
    v0 = vc;
    step(20);
    chk("disabled_no_valid", 32'(vc - v0), 32'h0);
    chk("disabled_held", 32'(bus.mappedMovement), 32'h9);
    bus.enable = 1'b1;
    wait_valid("reenable_commit", 4'b1111, 1);
    step(2);

    // Reset lands mid-debounce of 0111.
    bus.mode = 2'b00;
    step(3);
    bus.movement = 4'b0111;
    step(5);
    reset_n = 1'b0;
    #1;
    chk("async_reset_mapped", 32'(bus.mappedMovement), 32'h0);
    chk("async_reset_valid", 32'(bus.valid), 32'h0);
    step(1);
    reset_n = 1'b1;
    wait_valid("after_reset_0111", 4'b0111, 7);
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
